// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, mstatus/mie bit positions and small decode helpers
// for the machine-mode CSR register file.
package csr_regfile_pkg;

    localparam int CSR_IDX_WIDTH = 12;

    localparam logic [11:0] CSR_MSTATUS_IDX   = 12'h300;
    localparam logic [11:0] CSR_MISA_IDX      = 12'h301;
    localparam logic [11:0] CSR_MIE_IDX       = 12'h304;
    localparam logic [11:0] CSR_MTVEC_IDX     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH_IDX  = 12'h340;
    localparam logic [11:0] CSR_MEPC_IDX      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE_IDX    = 12'h342;
    localparam logic [11:0] CSR_MTVAL_IDX     = 12'h343;
    localparam logic [11:0] CSR_MIP_IDX       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID_IDX = 12'hF11;
    localparam logic [11:0] CSR_MARCHID_IDX   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID_IDX    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID_IDX   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE_IDX    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET_IDX  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH_IDX   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH_IDX = 12'hB82;
    localparam logic [11:0] CSR_CYCLE_IDX     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET_IDX   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH_IDX    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH_IDX  = 12'hC82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // mie/mip are stored compactly as {MEIP/MEIE, MTIP/MTIE, MSIP/MSIE}
    localparam int IRQ_SFT_BIT = 3;
    localparam int IRQ_TMR_BIT = 7;
    localparam int IRQ_EXT_BIT = 11;

    // CSR indices with [11:10]==2'b11 are read-only by the privileged encoding
    function automatic logic is_ro_space(input logic [11:0] idx);
        return idx[11:10] == 2'b11;
    endfunction

    // Expand a compact {ext,tmr,sft} triple into its mie/mip word layout
    function automatic logic [31:0] irq_word(input logic [2:0] b);
        return {20'b0, b[2], 3'b0, b[1], 3'b0, b[0], 3'b0};
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Command interface between csr_ctrl (master) and csr_regfile (slave).
interface csr_regfile_if;
    import csr_regfile_pkg::*;

    logic                     csr_rd_en;
    logic                     csr_wr_en;
    logic [CSR_IDX_WIDTH-1:0] csr_idx;
    logic [31:0]              csr_cmd_wdata;
    logic                     csr_ena;
    logic [31:0]              csr_cmd_rdata;
    logic                     csr_access_ilgl;

    modport master (
        output csr_rd_en, csr_wr_en, csr_idx, csr_cmd_wdata, csr_ena,
        input  csr_cmd_rdata, csr_access_ilgl
    );

    modport slave (
        input  csr_rd_en, csr_wr_en, csr_idx, csr_cmd_wdata, csr_ena,
        output csr_cmd_rdata, csr_access_ilgl
    );

endinterface

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with independently writable halves.
// A write to either half suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    // Write replaces one half; otherwise count with full 64-bit carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 64'd0;
        end else if (wr_lo) begin
            value[31:0] <= wdata;
        end else if (wr_hi) begin
            value[63:32] <= wdata;
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file, responder to csr_ctrl.
// Read data and the illegal-access flag depend only on the command index and
// enables, never on write data, so csr_ctrl may loop rdata back into wdata.
// Build option: CSR_PERF_CNT_EN adds mcycle/minstret and their user shadows;
// without it those addresses decode as illegal and no counter flops exist.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic         clk,
    input  logic         rst,
    csr_regfile_if.slave bus,
    input  logic         trap_valid,
    input  logic [31:0]  trap_cause,
    input  logic [31:0]  trap_pc,
    input  logic [31:0]  trap_tval,
    input  logic         mret_valid,
    input  logic         instr_retire,
    input  logic         irq_ext,
    input  logic         irq_tmr,
    input  logic         irq_sft,
    output logic [31:0]  csr_mtvec,
    output logic [31:0]  csr_mepc,
    output logic         irq_pending
);

    logic        mstatus_mie, mstatus_mpie;
    logic [2:0]  mie_q, mip_q;
    logic [29:0] mtvec_q, mepc_q;
    logic [31:0] mscratch_q, mcause_q, mtval_q;
    logic [31:0] mstatus_word;
    logic [31:0] rd_raw;
    logic        rd_hit;
    logic        wr_commit;

    assign mstatus_word = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

`ifdef CSR_PERF_CNT_EN
    logic [63:0] cycle_q, instret_q;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_commit && bus.csr_idx == CSR_MCYCLE_IDX),
        .wr_hi (wr_commit && bus.csr_idx == CSR_MCYCLEH_IDX),
        .wdata (bus.csr_cmd_wdata),
        .value (cycle_q)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .wr_lo (wr_commit && bus.csr_idx == CSR_MINSTRET_IDX),
        .wr_hi (wr_commit && bus.csr_idx == CSR_MINSTRETH_IDX),
        .wdata (bus.csr_cmd_wdata),
        .value (instret_q)
    );
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

    // Address decode and read mux, driven by csr_idx only
    always_comb begin
        rd_hit = 1'b1;
        rd_raw = 32'd0;
        case (bus.csr_idx)
            CSR_MSTATUS_IDX:   rd_raw = mstatus_word;
            CSR_MISA_IDX:      rd_raw = MISA_VAL;
            CSR_MIE_IDX:       rd_raw = irq_word(mie_q);
            CSR_MTVEC_IDX:     rd_raw = {mtvec_q, 2'b00};
            CSR_MSCRATCH_IDX:  rd_raw = mscratch_q;
            CSR_MEPC_IDX:      rd_raw = {mepc_q, 2'b00};
            CSR_MCAUSE_IDX:    rd_raw = mcause_q;
            CSR_MTVAL_IDX:     rd_raw = mtval_q;
            CSR_MIP_IDX:       rd_raw = irq_word(mip_q);
            CSR_MVENDORID_IDX: rd_raw = 32'd0;
            CSR_MARCHID_IDX:   rd_raw = 32'd0;
            CSR_MIMPID_IDX:    rd_raw = 32'd0;
            CSR_MHARTID_IDX:   rd_raw = HART_ID;
`ifdef CSR_PERF_CNT_EN
            CSR_MCYCLE_IDX, CSR_CYCLE_IDX:       rd_raw = cycle_q[31:0];
            CSR_MCYCLEH_IDX, CSR_CYCLEH_IDX:     rd_raw = cycle_q[63:32];
            CSR_MINSTRET_IDX, CSR_INSTRET_IDX:   rd_raw = instret_q[31:0];
            CSR_MINSTRETH_IDX, CSR_INSTRETH_IDX: rd_raw = instret_q[63:32];
`endif
            default:           rd_hit = 1'b0;
        endcase
    end

    assign bus.csr_access_ilgl = ((bus.csr_rd_en | bus.csr_wr_en) & ~rd_hit)
                               | (bus.csr_wr_en & is_ro_space(bus.csr_idx));
    assign bus.csr_cmd_rdata   = (bus.csr_rd_en & ~bus.csr_access_ilgl) ? rd_raw : 32'd0;
    assign wr_commit           = bus.csr_wr_en & bus.csr_ena & ~bus.csr_access_ilgl;

    assign csr_mtvec = {mtvec_q, 2'b00};
    assign csr_mepc  = {mepc_q, 2'b00};

    // mstatus: trap beats mret beats software write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_valid) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_valid) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_commit && bus.csr_idx == CSR_MSTATUS_IDX) begin
            mstatus_mie  <= bus.csr_cmd_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie <= bus.csr_cmd_wdata[MSTATUS_MPIE_BIT];
        end
    end

    // Trap-updated registers: a trap overrides a same-cycle software write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_q   <= 30'd0;
            mcause_q <= 32'd0;
            mtval_q  <= 32'd0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc[31:2];
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
        end else if (wr_commit) begin
            if (bus.csr_idx == CSR_MEPC_IDX)   mepc_q   <= bus.csr_cmd_wdata[31:2];
            if (bus.csr_idx == CSR_MCAUSE_IDX) mcause_q <= bus.csr_cmd_wdata;
            if (bus.csr_idx == CSR_MTVAL_IDX)  mtval_q  <= bus.csr_cmd_wdata;
        end
    end

    // Software-only registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 3'd0;
            mtvec_q    <= 30'd0;
            mscratch_q <= 32'd0;
        end else if (wr_commit) begin
            if (bus.csr_idx == CSR_MIE_IDX)
                mie_q <= {bus.csr_cmd_wdata[IRQ_EXT_BIT], bus.csr_cmd_wdata[IRQ_TMR_BIT],
                          bus.csr_cmd_wdata[IRQ_SFT_BIT]};
            if (bus.csr_idx == CSR_MTVEC_IDX)    mtvec_q    <= bus.csr_cmd_wdata[31:2];
            if (bus.csr_idx == CSR_MSCRATCH_IDX) mscratch_q <= bus.csr_cmd_wdata;
        end
    end

    // Sample irq lines into mip, then register the qualified pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_q       <= 3'd0;
            irq_pending <= 1'b0;
        end else begin
            mip_q       <= {irq_ext, irq_tmr, irq_sft};
            irq_pending <= (|(mip_q & mie_q)) & mstatus_mie;
        end
    end

endmodule
